fsm_seq_ctrl: RTL
=================

// Module: fsm_seq_ctrl
// PURPOSE
//  Stimulus sequencer and cross-checker for the 2-bit-input / 3-bit-output FSM implementations.
//  Holds a programmable symbol sequence and resets all FSM instances through a shared low reset.
//  Plays the sequence on their shared input 'a', then compares the case, memory and gate outputs on every step.
//  Replaces hand-written #delay stimulus in the testbench with a reusable, self-checking controller.
// PARAMETERS
//  AW       4  program address width; program depth = 2**AW symbols
//  HOLD     4  clock cycles each symbol is held on 'a' (legal >= 2)
//  RST_CYC  2  cycles fsm_res_n is held low before the first symbol (legal >= 1)
// PORTS
//  clk        in   1     system clock, all logic on posedge
//  reset      in   1     synchronous, active-high reset
//  wr_en      in   1     program write strobe (ignored while busy=1)
//  wr_addr    in   AW    program write address
//  wr_data    in   2     symbol to store
//  seq_len    in   AW+1  number of symbols to play, sampled at start; values > 2**AW clamp to 2**AW
//  start      in   1     begin a run (ignored while busy=1)
//  fsm_res_n  out  1     active-low reset to all FSM instances
//  a          out  2     current symbol driven to all FSM instances
//  s_case     in   3     output of the case-statement FSM
//  s_mem      in   3     output of the memory-table FSM
//  s_gate     in   3     output of the gate-level FSM
//  busy       out  1     run in progress (state RST or RUN)
//  done       out  1     one-cycle pulse at the end of a run
//  step       out  AW    index of the symbol currently on 'a'
//  err_count  out  AW+1  number of steps with a mismatch in the current or last run
//  err_step   out  AW    step index of the first mismatch (valid when err_count != 0)
//  mismatch   out  1     sticky; set on first mismatch, cleared by the next start
// BEHAVIOUR
//  - All outputs are registered. While reset=1 at a clk edge:
//      state=IDLE, fsm_res_n=0, a=0, step=0, busy=0, done=0, err_count=0, err_step=0, mismatch=0.
//  - The program memory (2**AW x 2 bits) is not cleared by reset.
//  - IDLE: fsm_res_n=1, a=0, busy=0.
//      - wr_en writes wr_data into prog[wr_addr].
//      - start=1: latch the clamped seq_len as len, clear err_count, err_step and mismatch,
//        set step=0 and cnt=0, drive fsm_res_n=0, then go to RST.
//  - RST: fsm_res_n=0 and a=0 for exactly RST_CYC cycles.
//      - If len=0: go to DONE.
//      - Otherwise, on the exit edge: fsm_res_n=1, a=prog[0], cnt=0, go to RUN.
//  - RUN: a=prog[step]. cnt increments every cycle.
//      - On the cycle cnt==HOLD-1, sample the outputs.
//        Mismatch condition: (s_case!=s_mem) || (s_case!=s_gate).
//      - On a mismatch: err_count+=1 and mismatch<=1. If this is the first mismatch, err_step<=step.
//      - If step==len-1: go to DONE, a=0.
//      - Else: step+=1, a=prog[step+1], cnt=0.
//  - DONE: done=1 for one cycle, busy=0, then IDLE.
//      - err_count, err_step and mismatch hold until the next start.
//  - Latency: the done pulse appears exactly 1+RST_CYC+len*HOLD cycles after the edge that samples start.
//  - Simultaneous events:
//      - start and wr_en in the same IDLE cycle: the write completes, and the run uses the new contents.
//      - wr_en and start during busy are dropped; the program is unchanged.
//  - Reset mid-run: the run aborts on the next edge, with reset values as above.
//    fsm_res_n=0 while reset=1, so all FSMs return to state zero.
//  - err_count cannot overflow: at most 2**AW increments per run.
// TESTING
//  1. Play 1,1,0,0,1,2,1,0,2 with len=9, HOLD=4, RST_CYC=2, and all three s_* tied to one golden FSM
//     -> 'a' follows that order, done at cycle 39 after start, err_count=0, mismatch=0.
//  2. Same run, with s_gate bit0 inverted only while step==3
//     -> err_count=1, err_step=3, mismatch=1; the remaining steps still play.
//  3. len=0 -> fsm_res_n low for 2 cycles, done at cycle 3, 'a' stays 0, err_count=0.
//  4. Pulse start and wr_en(addr 0, data 3) at step 2 of a len=5 run
//     -> no restart, prog[0] unchanged, done at cycle 23.
//  5. Assert reset at step 4 of a len=9 run
//     -> next edge: busy=0, fsm_res_n=0, a=0; a following start replays from step 0.
//  6. seq_len=20 with AW=4 -> 16 symbols played (steps 0..15), done at cycle 67.

Source files
------------

// File: rtl/fsm_seq_ctrl.sv
// Stimulus sequencer and cross-checker for the case, memory and gate FSM implementations.
// Plays a programmed symbol sequence on 'a' and counts steps where the three outputs disagree.
module fsm_seq_ctrl #(
   parameter int unsigned AW      = 4,
   parameter int unsigned HOLD    = 4,
   parameter int unsigned RST_CYC = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [1:0]    wr_data,
   input  logic [AW:0]   seq_len,
   input  logic          start,
   output logic          fsm_res_n,
   output logic [1:0]    a,
   input  logic [2:0]    s_case,
   input  logic [2:0]    s_mem,
   input  logic [2:0]    s_gate,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] step,
   output logic [AW:0]   err_count,
   output logic [AW-1:0] err_step,
   output logic          mismatch
);

   localparam int unsigned Depth  = 1 << AW;
   localparam int unsigned CntMax = (HOLD > RST_CYC) ? HOLD : RST_CYC;
   localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;

   typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] step_q, step_d;
   logic [1:0]    a_q, a_d;
   logic          res_n_q, res_n_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW:0]   err_count_q, err_count_d;
   logic [AW-1:0] err_step_q, err_step_d;
   logic          mismatch_q, mismatch_d;

   logic [1:0]    prog [Depth];
   logic          prog_we;
   logic          outs_differ;
   logic          last_step;
   logic [AW-1:0] step_inc;
   logic [AW:0]   len_clamped;

   assign outs_differ = (s_case != s_mem) || (s_case != s_gate);
   assign last_step   = ({1'b0, step_q} == (len_q - 1'b1));
   assign step_inc    = step_q + 1'b1;
   assign len_clamped = (seq_len > (AW+1)'(Depth)) ? (AW+1)'(Depth) : seq_len;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      step_d      = step_q;
      a_d         = a_q;
      res_n_d     = res_n_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_count_d = err_count_q;
      err_step_d  = err_step_q;
      mismatch_d  = mismatch_q;
      prog_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            res_n_d = 1'b1;
            a_d     = 2'b00;
            busy_d  = 1'b0;
            prog_we = wr_en;
            if (start) begin
               len_d       = len_clamped;
               err_count_d = '0;
               err_step_d  = '0;
               mismatch_d  = 1'b0;
               step_d      = '0;
               cnt_d       = '0;
               res_n_d     = 1'b0;
               busy_d      = 1'b1;
               state_d     = StRst;
            end
         end
         StRst: begin
            res_n_d = 1'b0;
            a_d     = 2'b00;
            if (cnt_q == CW'(RST_CYC - 1)) begin
               cnt_d   = '0;
               res_n_d = 1'b1;
               if (len_q == '0) begin
                  busy_d  = 1'b0;
                  state_d = StDone;
               end else begin
                  a_d     = prog[0];
                  state_d = StRun;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            // Outputs are compared on the last cycle each symbol is held, once the FSMs settled.
            if (cnt_q == CW'(HOLD - 1)) begin
               cnt_d = '0;
               if (outs_differ) begin
                  err_count_d = err_count_q + 1'b1;
                  mismatch_d  = 1'b1;
                  if (err_count_q == '0) begin
                     err_step_d = step_q;
                  end
               end
               if (last_step) begin
                  a_d     = 2'b00;
                  busy_d  = 1'b0;
                  state_d = StDone;
               end else begin
                  step_d = step_inc;
                  a_d    = prog[step_inc];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            prog_we = wr_en;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         len_q       <= '0;
         step_q      <= '0;
         a_q         <= 2'b00;
         res_n_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_count_q <= '0;
         err_step_q  <= '0;
         mismatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         step_q      <= step_d;
         a_q         <= a_d;
         res_n_q     <= res_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_count_q <= err_count_d;
         err_step_q  <= err_step_d;
         mismatch_q  <= mismatch_d;
      end
   end

   // Program storage survives reset so a run can be replayed after an abort.
   always_ff @(posedge clk) begin
      if (prog_we && !reset) begin
         prog[wr_addr] <= wr_data;
      end
   end

   assign fsm_res_n = res_n_q;
   assign a         = a_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign step      = step_q;
   assign err_count = err_count_q;
   assign err_step  = err_step_q;
   assign mismatch  = mismatch_q;

endmodule
